// File: rtl/irrigation_countdown_pkg.sv
// Shared types and constants for the irrigation countdown timer.
// States, BCD digit limits, mode presets and clamp helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_EXPIRED
  } state_e;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RUN     = ST_RUN;
  localparam logic [1:0] S_HOLD    = ST_HOLD;
  localparam logic [1:0] S_EXPIRED = ST_EXPIRED;

  localparam logic [2:0] SEC_D_MAX = 3'd5;
  localparam logic [3:0] MIN_U_MAX = 4'd9;
  localparam logic [3:0] SEC_U_MAX = 4'd9;
  localparam logic [1:0] MIN_D_MAX = 2'd3;

  localparam logic [1:0] SPRINKLER_MIN_D = 2'd1;
  localparam logic [3:0] SPRINKLER_MIN_U = 4'd5;
  localparam logic [1:0] DRIPPER_MIN_D   = 2'd3;
  localparam logic [3:0] DRIPPER_MIN_U   = 4'd0;

  function automatic logic [3:0] clamp_min_u(
    input logic [3:0] v
  );
    return (v > MIN_U_MAX) ? MIN_U_MAX : v;
  endfunction

  function automatic logic [2:0] clamp_sec_d(
    input logic [2:0] v
  );
    return (v > SEC_D_MAX) ? SEC_D_MAX : v;
  endfunction

endpackage

// File: rtl/irrigation_countdown_if.sv
// Control/preset inputs and MM:SS status outputs of the countdown.
// master drives load/presets/enables, slave is the timer.
interface irrigation_countdown_if;
  logic       load;
  logic [1:0] minutes_d_preset;
  logic [3:0] minutes_u_preset;
  logic [2:0] seconds_d_preset;
  logic       irrigation_on;
  logic       tick_1hz;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic [3:0] seconds_u;
  logic       running;
  logic       expired;
  logic       preset_clamped;

  modport master (
    output load, minutes_d_preset,
    output minutes_u_preset,
    output seconds_d_preset,
    output irrigation_on, tick_1hz,
    input  minutes_d, minutes_u,
    input  seconds_d, seconds_u,
    input  running, expired,
    input  preset_clamped
  );

  modport slave (
    input  load, minutes_d_preset,
    input  minutes_u_preset,
    input  seconds_d_preset,
    input  irrigation_on, tick_1hz,
    output minutes_d, minutes_u,
    output seconds_d, seconds_u,
    output running, expired,
    output preset_clamped
  );
endinterface

// File: rtl/irrigation_countdown_bcd_digit_down.sv
// One loadable down-counting digit of the countdown borrow chain.
// Wraps 0 -> WRAP when a borrow arrives while decrementing.
module bcd_digit_down #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   WRAP = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  input  logic         borrow_in,
  output logic [W-1:0] digit,
  output logic         borrow_out
);

  logic [W-1:0] q;

  assign digit      = q;
  assign borrow_out = dec_en & borrow_in
                    & (q == '0);

  // digit register: reset, then load, then decrement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec_en && borrow_in) begin
      q <= (q == '0) ? WRAP : q - W'(1);
    end
  end

endmodule

// File: rtl/irrigation_countdown.sv
// MM:SS BCD irrigation countdown; optional TIMER_PRESCALER_EN
// derives the 1 Hz tick from clk instead of tick_1hz.
module irrigation_countdown
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  irrigation_countdown_if.slave bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       exp_nxt;
  logic       running_q;
  logic       expired_q;
  logic       clamped_q;
  logic       tick_eff;
  logic       dec_en;
  logic       at_one;

  logic [3:0] mu_ld;
  logic [2:0] sd_ld;
  logic       clamp_any;
  logic       load_zero;

  logic [1:0] md;
  logic [3:0] mu;
  logic [2:0] sd;
  logic [3:0] su;
  logic       b_su;
  logic       b_sd;
  logic       b_mu;
  logic       b_md;

  assign mu_ld     = clamp_min_u(bus.minutes_u_preset);
  assign sd_ld     = clamp_sec_d(bus.seconds_d_preset);
  assign clamp_any = (bus.minutes_u_preset > MIN_U_MAX)
                   | (bus.seconds_d_preset > SEC_D_MAX);
  assign load_zero = (bus.minutes_d_preset == 2'd0)
                   & (mu_ld == 4'd0)
                   & (sd_ld == 3'd0);

  assign at_one = (md == 2'd0) & (mu == 4'd0)
                & (sd == 3'd0) & (su == 4'd1);

`ifdef TIMER_PRESCALER_EN
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  logic [PW-1:0] pre_q;
  logic          unused_tick;

  assign unused_tick = bus.tick_1hz;
  assign tick_eff    = (state == S_RUN)
                     & (pre_q == PW'(CLK_HZ - 1));

  // prescaler: cleared on load, advances only in RUN
  always_ff @(posedge clk) begin
    if (!rst_n || bus.load) begin
      pre_q <= '0;
    end else if (state == S_RUN) begin
      pre_q <= tick_eff ? '0 : pre_q + PW'(1);
    end
  end
`else
  logic unused_clk_hz;

  assign unused_clk_hz = (CLK_HZ != 0);
  assign tick_eff      = bus.tick_1hz;
`endif

  assign dec_en = tick_eff & (state == S_RUN)
                & ~bus.load;

  // next state and expiry pulse; load overrides tick and enable
  always_comb begin
    state_nxt = state;
    exp_nxt   = 1'b0;
    if (bus.load) begin
      if (load_zero) begin
        state_nxt = S_EXPIRED;
        exp_nxt   = 1'b1;
      end else begin
        state_nxt = bus.irrigation_on ? S_RUN : S_HOLD;
      end
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_RUN: begin
          if (tick_eff && at_one) begin
            state_nxt = S_EXPIRED;
            exp_nxt   = 1'b1;
          end else if (!bus.irrigation_on) begin
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.irrigation_on) state_nxt = S_RUN;
        end
        S_EXPIRED: state_nxt = S_EXPIRED;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      running_q <= (state_nxt == S_RUN);
      expired_q <= exp_nxt;
      if (bus.load) clamped_q <= clamp_any;
    end
  end

  bcd_digit_down #(.W(4), .WRAP(SEC_U_MAX)) u_su (
    .clk(clk), .rst_n(rst_n),
    .load(bus.load), .load_val(4'd0),
    .dec_en(dec_en), .borrow_in(1'b1),
    .digit(su), .borrow_out(b_su)
  );

  bcd_digit_down #(.W(3), .WRAP(SEC_D_MAX)) u_sd (
    .clk(clk), .rst_n(rst_n),
    .load(bus.load), .load_val(sd_ld),
    .dec_en(dec_en), .borrow_in(b_su),
    .digit(sd), .borrow_out(b_sd)
  );

  bcd_digit_down #(.W(4), .WRAP(MIN_U_MAX)) u_mu (
    .clk(clk), .rst_n(rst_n),
    .load(bus.load), .load_val(mu_ld),
    .dec_en(dec_en), .borrow_in(b_sd),
    .digit(mu), .borrow_out(b_mu)
  );

  bcd_digit_down #(.W(2), .WRAP(MIN_D_MAX)) u_md (
    .clk(clk), .rst_n(rst_n),
    .load(bus.load),
    .load_val(bus.minutes_d_preset),
    .dec_en(dec_en), .borrow_in(b_mu),
    .digit(md), .borrow_out(b_md)
  );

  logic unused_b_md;
  assign unused_b_md = b_md;

  assign bus.minutes_d      = md;
  assign bus.minutes_u      = mu;
  assign bus.seconds_d      = sd;
  assign bus.seconds_u      = su;
  assign bus.running        = running_q;
  assign bus.expired        = expired_q;
  assign bus.preset_clamped = clamped_q;

endmodule

// File: doc/irrigation_countdown.md
# irrigation_countdown

Registered BCD countdown timer for the irrigation controller, directly downstream of the timer reset/preset stage. Loads the mode preset (15:00 sprinkler, 30:00 dripper) in MM:S0 form on a load request, then counts down one second per tick while irrigation is on. Drives the MM:SS digits consumed by the display/reseter loop and pulses `expired` when 00:00 is reached.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency; used only when the internal prescaler is compiled in.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `load`  in  1  level; the preset is loaded on every edge where it is high. Driven by the reseter's reset term.
- `minutes_d_preset`  in  2  preset minutes tens (0–3).
- `minutes_u_preset`  in  4  preset minutes units (0–9).
- `seconds_d_preset`  in  3  preset seconds tens (0–5).
- `irrigation_on`  in  1  count enable; low holds the count.
- `tick_1hz`  in  1  one-cycle 1 Hz strobe. Ignored when `TIMER_PRESCALER_EN` is defined.
- `minutes_d`  out  2  current minutes tens.
- `minutes_u`  out  4  current minutes units.
- `seconds_d`  out  3  current seconds tens.
- `seconds_u`  out  4  current seconds units.
- `running`  out  1  high in RUN.
- `expired`  out  1  one-cycle pulse on reaching 00:00.
- `preset_clamped`  out  1  registered; high if the last load clamped an out-of-range digit.

## Operation
- States: IDLE, RUN, HOLD, EXPIRED.
- IDLE: count frozen. `load` moves to RUN, or to HOLD if `irrigation_on` is low.
- RUN: on a tick, decrement the 4-digit BCD value.
  - `seconds_u` 0→9 borrows from `seconds_d`.
  - `seconds_d` 0→5 borrows from `minutes_u`.
  - `minutes_u` 0→9 borrows from `minutes_d`.
  - `irrigation_on` low moves to HOLD. The count is kept and ticks are ignored.
- HOLD: `irrigation_on` high returns to RUN. Ticks in the return cycle are ignored.
- Tick that produces 00:00 (from 00:01): move to EXPIRED and assert `expired` for exactly one cycle, on the edge after that tick.
- EXPIRED: count stays at 00:00. Only `load` leaves this state.
- Load: `seconds_u` ← 0 and the three preset digits are registered.
  - `minutes_u_preset` > 9 clamps to 9; `seconds_d_preset` > 5 clamps to 5. A clamp sets `preset_clamped`; a clean load clears it.
  - A loaded value of 00:00 goes to EXPIRED and pulses `expired` on the next edge.
- Priority: `rst_n` > `load` > tick > `irrigation_on` transitions.
  - `load` and tick in the same cycle: load wins and the tick is dropped.
- Decrement never underflows: a tick at 00:00 is impossible outside EXPIRED. Any illegal state decodes to IDLE.

## Timing
- Reset (`rst_n` low at an edge): state IDLE; all digits 0; `running`, `expired`, `preset_clamped` all 0.
- All outputs are registered; there is no combinational input→output path.
- Load latency: 1 cycle. Presets are visible on the outputs the edge after `load` is sampled.
- Tick→digit update latency: 1 cycle.
- A 15:00 load with `irrigation_on` held high reaches 00:00 after exactly 900 ticks; 30:00 after 1800.
- Reset asserted mid-count discards the count in the same edge.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - An internal counter divides `clk` by `CLK_HZ` to create the tick; `tick_1hz` is ignored.
  - The prescaler is cleared by reset and by `load`, so the first decrement occurs exactly `CLK_HZ` cycles after the load.
  - It counts only in RUN and freezes in HOLD, keeping the partial second.
- Not defined: `tick_1hz` is used directly and no prescaler logic exists.

## Structure
- Package `timer_pkg`:
  - state enum (IDLE, RUN, HOLD, EXPIRED);
  - digit limits `SEC_D_MAX`=5, `MIN_U_MAX`=9, `SEC_U_MAX`=9, `MIN_D_MAX`=3;
  - mode constants 15:00 and 30:00.
- One sub-module, `bcd_digit_down`:
  - parameter: width and wrap value;
  - inputs: load, load value, decrement enable, borrow-in;
  - outputs: digit, borrow-out (digit==0 and decrementing).
  - Instantiated four times in a borrow chain.

## Test plan
- Reset: after `rst_n` low then high, outputs are 00:00 with `running`=0 and `expired`=0; ticks do not change the count.
- Load 1,5,0 with `irrigation_on`=1, then 1 tick: 14:59 one cycle after the tick; after 899 more ticks, 00:00 with a single `expired` pulse.
- Borrow chain: load 1,0,0 and tick once → 09:59; load 0,1,0 and tick once → 00:59.
- Hold: drop `irrigation_on` at 12:34 and send 10 ticks → count stays 12:34 in HOLD; raise it → resumes from 12:34.
- Load on the same cycle as a tick at 05:00, preset 3,0,0 → 30:00 and the tick is lost; presets 0,C,7 → 09:50 with `preset_clamped`=1.
- Zero preset: load 0,0,0 → EXPIRED and a one-cycle `expired` pulse on the next edge; with `TIMER_PRESCALER_EN` and `CLK_HZ`=10, the first decrement occurs 10 cycles after load.
